// File: rtl/sd_cmd_sequencer.sv
// SD-card SPI-mode command sequencer: CS, CMD frame with CRC7, R1 poll, optional
// single-block read into the DMA FIFO, then deselect with trailing clocks.
module sd_cmd_sequencer #(
    parameter int unsigned R1_TIMEOUT    = 8,
    parameter int unsigned TOKEN_TIMEOUT = 4096,
    parameter int unsigned BLOCK_LEN     = 512
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_start,
    input  logic [5:0]  i_cmd_index,
    input  logic [31:0] i_cmd_arg,
    input  logic        i_cmd_read_block,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_r1,
    output logic [1:0]  o_error,
    output logic        o_sd_cs,
    output logic        o_spi_start,
    output logic [7:0]  o_spi_tx_data,
    output logic        o_spi_start_multi,
    output logic [8:0]  o_spi_multi_length,
    output logic        o_spi_multi_dma,
    output logic        o_spi_rx_only,
    output logic        o_dma_start,
    input  logic        i_spi_busy,
    input  logic [7:0]  i_spi_rx_data
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] R1_LIMIT  = CNT_W'(R1_TIMEOUT);
    localparam logic [CNT_W-1:0] TOK_LIMIT = CNT_W'(TOKEN_TIMEOUT);
    localparam logic [8:0]       MULTI_LEN = 9'(BLOCK_LEN - 1);

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_R1_TO = 2'd1;
    localparam logic [1:0] ERR_R1    = 2'd2;
    localparam logic [1:0] ERR_TOKEN = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_R1, ST_TOKEN, ST_DATA, ST_CRC, ST_FIN
    } state_t;

    // Engine handshake: ISSUE -> PULSE (start high) -> GAP (busy not yet valid) -> WAIT
    typedef enum logic [1:0] {
        PH_ISSUE, PH_PULSE, PH_GAP, PH_WAIT
    } phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
    logic [6:0]        crc_q, crc_d;
    logic [5:0]        idx_q, idx_d;
    logic [31:0]       arg_q, arg_d;
    logic              rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        r1_q, r1_d;
    logic [1:0]        err_q, err_d;
    logic              sd_cs_q, sd_cs_d;
    logic              spi_start_q, spi_start_d;
    logic [7:0]        tx_q, tx_d;
    logic              multi_q, multi_d;
    logic [8:0]        mlen_q, mlen_d;
    logic              mdma_q, mdma_d;
    logic              rx_only_q, rx_only_d;
    logic              dma_start_q, dma_start_d;

    logic              issue_c;
    logic              xfer_done_c;
    logic [7:0]        cmd_byte_c;
    logic [CNT_W-1:0]  poll_inc_c;

    // CRC7, polynomial x^7 + x^3 + 1, MSB-first over one byte
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] d);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
        end
        return c;
    endfunction

    assign issue_c     = (phase_q == PH_ISSUE) && !i_spi_busy;
    assign xfer_done_c = (phase_q == PH_WAIT) && !i_spi_busy;
    assign poll_inc_c  = (poll_cnt_q == {CNT_W{1'b1}}) ? poll_cnt_q : poll_cnt_q + CNT_W'(1);

    always_comb begin
        unique case (byte_cnt_q)
            3'd0:    cmd_byte_c = {2'b01, idx_q};
            3'd1:    cmd_byte_c = arg_q[31:24];
            3'd2:    cmd_byte_c = arg_q[23:16];
            3'd3:    cmd_byte_c = arg_q[15:8];
            3'd4:    cmd_byte_c = arg_q[7:0];
            default: cmd_byte_c = {crc_q, 1'b1};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        byte_cnt_d  = byte_cnt_q;
        poll_cnt_d  = poll_cnt_q;
        crc_d       = crc_q;
        idx_d       = idx_q;
        arg_d       = arg_q;
        rd_d        = rd_q;
        busy_d      = busy_q;
        r1_d        = r1_q;
        err_d       = err_q;
        sd_cs_d     = sd_cs_q;
        tx_d        = tx_q;
        mlen_d      = mlen_q;
        mdma_d      = mdma_q;
        rx_only_d   = rx_only_q;
        done_d      = 1'b0;
        spi_start_d = 1'b0;
        multi_d     = 1'b0;
        dma_start_d = 1'b0;

        unique case (phase_q)
            PH_PULSE: phase_d = PH_GAP;
            PH_GAP:   phase_d = PH_WAIT;
            default:  ;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_start && !done_q) begin
                    idx_d      = i_cmd_index;
                    arg_d      = i_cmd_arg;
                    rd_d       = i_cmd_read_block;
                    busy_d     = 1'b1;
                    sd_cs_d    = 1'b0;
                    err_d      = ERR_OK;
                    crc_d      = 7'd0;
                    byte_cnt_d = 3'd0;
                    poll_cnt_d = '0;
                    phase_d    = PH_ISSUE;
                    state_d    = ST_CMD;
                end
            end
            ST_CMD: begin
                if (issue_c) begin
                    spi_start_d = 1'b1;
                    tx_d        = cmd_byte_c;
                    phase_d     = PH_PULSE;
                    if (byte_cnt_q != 3'd5) begin
                        crc_d = crc7_byte(crc_q, cmd_byte_c);
                    end
                end
                if (xfer_done_c) begin
                    phase_d = PH_ISSUE;
                    if (byte_cnt_q == 3'd5) begin
                        poll_cnt_d = '0;
                        state_d    = ST_R1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            ST_R1: begin
                if (issue_c) begin
                    spi_start_d = 1'b1;
                    tx_d        = 8'hFF;
                    phase_d     = PH_PULSE;
                end
                if (xfer_done_c) begin
                    phase_d    = PH_ISSUE;
                    poll_cnt_d = poll_inc_c;
                    if (!i_spi_rx_data[7]) begin
                        r1_d = i_spi_rx_data;
                        if (i_spi_rx_data != 8'h00) begin
                            err_d   = ERR_R1;
                            state_d = ST_FIN;
                        end else if (rd_q) begin
                            poll_cnt_d = '0;
                            state_d    = ST_TOKEN;
                        end else begin
                            state_d = ST_FIN;
                        end
                    end else if (poll_inc_c == R1_LIMIT) begin
                        err_d   = ERR_R1_TO;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_TOKEN: begin
                if (issue_c) begin
                    spi_start_d = 1'b1;
                    tx_d        = 8'hFF;
                    phase_d     = PH_PULSE;
                end
                if (xfer_done_c) begin
                    phase_d    = PH_ISSUE;
                    poll_cnt_d = poll_inc_c;
                    if (i_spi_rx_data == 8'hFE) begin
                        dma_start_d = 1'b1;
                        state_d     = ST_DATA;
                    end else if (i_spi_rx_data[7:4] == 4'h0) begin
                        err_d   = ERR_TOKEN;
                        state_d = ST_FIN;
                    end else if (poll_inc_c == TOK_LIMIT) begin
                        err_d   = ERR_TOKEN;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_DATA: begin
                if (issue_c) begin
                    multi_d   = 1'b1;
                    mlen_d    = MULTI_LEN;
                    mdma_d    = 1'b1;
                    rx_only_d = 1'b1;
                    phase_d   = PH_PULSE;
                end
                if (xfer_done_c) begin
                    mdma_d     = 1'b0;
                    rx_only_d  = 1'b0;
                    byte_cnt_d = 3'd0;
                    phase_d    = PH_ISSUE;
                    state_d    = ST_CRC;
                end
            end
            ST_CRC: begin
                if (issue_c) begin
                    spi_start_d = 1'b1;
                    tx_d        = 8'hFF;
                    phase_d     = PH_PULSE;
                end
                if (xfer_done_c) begin
                    phase_d = PH_ISSUE;
                    if (byte_cnt_q == 3'd1) begin
                        state_d = ST_FIN;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            ST_FIN: begin
                // Raise CS on an idle engine first, then clock out the trailing byte
                if (issue_c) begin
                    if (!sd_cs_q) begin
                        sd_cs_d = 1'b1;
                    end else begin
                        spi_start_d = 1'b1;
                        tx_d        = 8'hFF;
                        phase_d     = PH_PULSE;
                    end
                end
                if (xfer_done_c) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    phase_d = PH_ISSUE;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_ISSUE;
            byte_cnt_q  <= 3'd0;
            poll_cnt_q  <= '0;
            crc_q       <= 7'd0;
            idx_q       <= 6'd0;
            arg_q       <= 32'd0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            r1_q        <= 8'd0;
            err_q       <= 2'd0;
            sd_cs_q     <= 1'b1;
            spi_start_q <= 1'b0;
            tx_q        <= 8'd0;
            multi_q     <= 1'b0;
            mlen_q      <= 9'd0;
            mdma_q      <= 1'b0;
            rx_only_q   <= 1'b0;
            dma_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            byte_cnt_q  <= byte_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            crc_q       <= crc_d;
            idx_q       <= idx_d;
            arg_q       <= arg_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            r1_q        <= r1_d;
            err_q       <= err_d;
            sd_cs_q     <= sd_cs_d;
            spi_start_q <= spi_start_d;
            tx_q        <= tx_d;
            multi_q     <= multi_d;
            mlen_q      <= mlen_d;
            mdma_q      <= mdma_d;
            rx_only_q   <= rx_only_d;
            dma_start_q <= dma_start_d;
        end
    end

    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_r1               = r1_q;
    assign o_error            = err_q;
    assign o_sd_cs            = sd_cs_q;
    assign o_spi_start        = spi_start_q;
    assign o_spi_tx_data      = tx_q;
    assign o_spi_start_multi  = multi_q;
    assign o_spi_multi_length = mlen_q;
    assign o_spi_multi_dma    = mdma_q;
    assign o_spi_rx_only      = rx_only_q;
    assign o_dma_start        = dma_start_q;

endmodule
